// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank responder.
// Holds NumRegs registers of DataWidth bits, answers AW/W with B and AR with R,
// and exposes every register in parallel on reg_q_o.
//
// Handshake rule for every channel: a beat transfers on a rising clk edge where
// valid and ready are both high; a raised valid and its payload stay put until
// that edge, and ready may depend on local state only, never on the same
// channel's valid.
module axi_lite_regfile #(
   parameter int unsigned                  AddrWidth    = 32,
   parameter int unsigned                  DataWidth    = 32,
   parameter int unsigned                  NumRegs      = 16,
   parameter logic [NumRegs-1:0]           ReadOnlyMask = '0,
   parameter logic [NumRegs*DataWidth-1:0] RegRstVal    = '0
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [AddrWidth-1:0]           aw_addr_i,
   input  logic                           aw_valid_i,
   output logic                           aw_ready_o,
   input  logic [DataWidth-1:0]           w_data_i,
   input  logic [DataWidth/8-1:0]         w_strb_i,
   input  logic                           w_valid_i,
   output logic                           w_ready_o,
   output logic [1:0]                     b_resp_o,
   output logic                           b_valid_o,
   input  logic                           b_ready_i,
   input  logic [AddrWidth-1:0]           ar_addr_i,
   input  logic                           ar_valid_i,
   output logic                           ar_ready_o,
   output logic [DataWidth-1:0]           r_data_o,
   output logic [1:0]                     r_resp_o,
   output logic                           r_valid_o,
   input  logic                           r_ready_i,
   output logic [NumRegs*DataWidth-1:0]   reg_q_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned OffWidth  = $clog2(StrbWidth);
   localparam int unsigned IdxWidth  = AddrWidth - OffWidth;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   logic                         aw_held_q;
   logic [IdxWidth-1:0]          aw_idx_q;
   logic                         w_held_q;
   logic [DataWidth-1:0]         w_data_q;
   logic [StrbWidth-1:0]         w_strb_q;
   logic                         b_valid_q;
   logic [1:0]                   b_resp_q;
   logic                         r_valid_q;
   logic [1:0]                   r_resp_q;
   logic [DataWidth-1:0]         r_data_q;
   logic [NumRegs*DataWidth-1:0] regs_q;

   logic [IdxWidth-1:0]          rd_idx;
   logic                         commit;
   logic                         wr_ok;
   logic                         rd_hit;
   logic [DataWidth-1:0]         rd_val;

   // Byte-offset address bits never select anything.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{aw_addr_i[OffWidth-1:0], ar_addr_i[OffWidth-1:0]};

   assign rd_idx     = ar_addr_i[AddrWidth-1:OffWidth];
   assign aw_ready_o = !aw_held_q;
   assign w_ready_o  = !w_held_q;
   assign ar_ready_o = !r_valid_q || r_ready_i;
   // A write retires once both halves are in and the B slot is free or draining.
   assign commit     = aw_held_q && w_held_q && (!b_valid_q || b_ready_i);

   assign b_valid_o  = b_valid_q;
   assign b_resp_o   = b_resp_q;
   assign r_valid_o  = r_valid_q;
   assign r_resp_o   = r_resp_q;
   assign r_data_o   = r_data_q;
   assign reg_q_o    = regs_q;

   // Decode the held write index and the live read index against the bank.
   always_comb begin
      wr_ok  = 1'b0;
      rd_hit = 1'b0;
      rd_val = '0;
      for (int i = 0; i < int'(NumRegs); i++) begin
         if (aw_idx_q == IdxWidth'(i)) wr_ok = !ReadOnlyMask[i];
         if (rd_idx == IdxWidth'(i)) begin
            rd_hit = 1'b1;
            rd_val = regs_q[i*DataWidth +: DataWidth];
         end
      end
   end

   // Single-entry AW and W holds; each fills on its own handshake, both empty on commit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end
         if (aw_valid_i && aw_ready_o) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= aw_addr_i[AddrWidth-1:OffWidth];
         end
         if (w_valid_i && w_ready_o) begin
            w_held_q <= 1'b1;
            w_data_q <= w_data_i;
            w_strb_q <= w_strb_i;
         end
      end
   end

   // Register bank: strobed byte update on a commit that hits a writable register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regs_q <= RegRstVal;
      end else if (commit && wr_ok) begin
         for (int i = 0; i < int'(NumRegs); i++) begin
            if (aw_idx_q == IdxWidth'(i)) begin
               for (int b = 0; b < int'(StrbWidth); b++) begin
                  if (w_strb_q[b]) regs_q[i*DataWidth + 8*b +: 8] <= w_data_q[8*b +: 8];
               end
            end
         end
      end
   end

   // B channel: load a response on commit, hold it until accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         b_valid_q <= 1'b0;
         b_resp_q  <= RespOkay;
      end else if (commit) begin
         b_valid_q <= 1'b1;
         b_resp_q  <= wr_ok ? RespOkay : RespSlvErr;
      end else if (b_ready_i) begin
         b_valid_q <= 1'b0;
      end
   end

   // R channel: sample the addressed register on AR handshake, hold until accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid_q <= 1'b0;
         r_resp_q  <= RespOkay;
         r_data_q  <= '0;
      end else if (ar_valid_i && ar_ready_o) begin
         r_valid_q <= 1'b1;
         r_resp_q  <= rd_hit ? RespOkay : RespSlvErr;
         r_data_q  <= rd_val;
      end else if (r_ready_i) begin
         r_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: vector table driven through a response scoreboard,
// then hand-written sequences for latency, ordering, backpressure and reset.
module tb_axi_lite_regfile;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 16;
   localparam logic [NR-1:0]    RO_MASK = 16'h0008;
   localparam logic [NR*DW-1:0] RST_VAL = (512'hA5A5A5A5 << (3*32)) | (512'h0000CAFE << (7*32));

   logic              clk;
   logic              rst_i;
   logic [AW-1:0]     aw_addr_i;
   logic              aw_valid_i;
   logic              aw_ready_o;
   logic [DW-1:0]     w_data_i;
   logic [DW/8-1:0]   w_strb_i;
   logic              w_valid_i;
   logic              w_ready_o;
   logic [1:0]        b_resp_o;
   logic              b_valid_o;
   logic              b_ready_i;
   logic [AW-1:0]     ar_addr_i;
   logic              ar_valid_i;
   logic              ar_ready_o;
   logic [DW-1:0]     r_data_o;
   logic [1:0]        r_resp_o;
   logic              r_valid_o;
   logic              r_ready_i;
   logic [NR*DW-1:0]  reg_q_o;

   axi_lite_regfile #(
      .AddrWidth(AW), .DataWidth(DW), .NumRegs(NR),
      .ReadOnlyMask(RO_MASK), .RegRstVal(RST_VAL)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
      .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
      .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
      .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
      .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
      .reg_q_o(reg_q_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [1:0]  exp_b_q[$];
   logic [33:0] exp_r_q[$];
   logic [31:0] exp_regs[NR];

   typedef struct {
      bit          rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] val;   // read data, or register value after the write
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_exp();
      for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
      exp_regs[3] = 32'hA5A5A5A5;
      exp_regs[7] = 32'h0000CAFE;
   endtask

   task automatic check_regs(input string name);
      for (int i = 0; i < NR; i++)
         chk($sformatf("%s_reg%0d", name, i), 64'(reg_q_o[i*DW +: DW]), 64'(exp_regs[i]));
   endtask

   // ---------------- drivers ----------------
   task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int  n;
      logic awhs, whs;
      aw_addr_i = a; w_data_i = d; w_strb_i = s;
      aw_valid_i = 1'b1; w_valid_i = 1'b1; n = 0;
      while ((aw_valid_i || w_valid_i) && n < 50) begin
         @(negedge clk);
         awhs = aw_valid_i && aw_ready_o;
         whs  = w_valid_i && w_ready_o;
         @(posedge clk); #1;
         if (awhs) aw_valid_i = 1'b0;
         if (whs)  w_valid_i  = 1'b0;
         n++;
      end
      chk("wr_handshake_stuck", 64'(aw_valid_i || w_valid_i), 64'(0));
      aw_valid_i = 1'b0; w_valid_i = 1'b0;
   endtask

   task automatic drive_rd(input logic [31:0] a);
      int  n;
      logic hs;
      ar_addr_i = a; ar_valid_i = 1'b1; n = 0;
      while (ar_valid_i && n < 50) begin
         @(negedge clk);
         hs = ar_ready_o;
         @(posedge clk); #1;
         if (hs) ar_valid_i = 1'b0;
         n++;
      end
      chk("rd_handshake_stuck", 64'(ar_valid_i), 64'(0));
      ar_valid_i = 1'b0;
   endtask

   task automatic collect_b(input string name);
      int n;
      logic [1:0] e;
      n = 0;
      do begin @(negedge clk); n++; end while (!b_valid_o && n < 20);
      chk({name, "_bvalid"}, 64'(b_valid_o), 64'(1));
      e = 2'bxx;
      if (exp_b_q.size() > 0) e = exp_b_q.pop_front();
      chk({name, "_bresp"}, 64'(b_resp_o), 64'(e));
      @(posedge clk); #1;
   endtask

   task automatic collect_r(input string name);
      int n;
      logic [33:0] e;
      n = 0;
      do begin @(negedge clk); n++; end while (!r_valid_o && n < 20);
      chk({name, "_rvalid"}, 64'(r_valid_o), 64'(1));
      e = 34'bx;
      if (exp_r_q.size() > 0) e = exp_r_q.pop_front();
      chk({name, "_rresp"}, 64'(r_resp_o), 64'(e[33:32]));
      chk({name, "_rdata"}, 64'(r_data_o), 64'(e[31:0]));
      @(posedge clk); #1;
   endtask

   // ---------------- test ----------------
   initial begin
      int n;
      vecs[0]  = '{1'b0, 32'h08,       32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 32'h08,       32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 32'h04,       32'hFFFFFFFF, 4'hF, 2'b00, 32'hFFFFFFFF};
      vecs[3]  = '{1'b0, 32'h40,       32'h11111111, 4'hF, 2'b10, 32'h0};
      vecs[4]  = '{1'b1, 32'h40,       32'h0,        4'h0, 2'b10, 32'h0};
      vecs[5]  = '{1'b0, 32'h0C,       32'h0,        4'hF, 2'b10, 32'hA5A5A5A5};
      vecs[6]  = '{1'b1, 32'h0C,       32'h0,        4'h0, 2'b00, 32'hA5A5A5A5};
      vecs[7]  = '{1'b0, 32'h3F,       32'h01020304, 4'h3, 2'b00, 32'h00000304};
      vecs[8]  = '{1'b0, 32'h3C,       32'hFFFFFFFF, 4'h0, 2'b00, 32'h00000304};
      vecs[9]  = '{1'b1, 32'h3D,       32'h0,        4'h0, 2'b00, 32'h00000304};
      vecs[10] = '{1'b1, 32'h1C,       32'h0,        4'h0, 2'b00, 32'h0000CAFE};
      vecs[11] = '{1'b0, 32'h1C,       32'hAABBCCDD, 4'hC, 2'b00, 32'hAABBCAFE};
      vecs[12] = '{1'b1, 32'h1E,       32'h0,        4'h0, 2'b00, 32'hAABBCAFE};
      vecs[13] = '{1'b1, 32'hFFFFFFFC, 32'h0,        4'h0, 2'b10, 32'h0};

      rst_i = 1'b1;
      aw_addr_i = '0; aw_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
      ar_addr_i = '0; ar_valid_i = 1'b0; b_ready_i = 1'b1; r_ready_i = 1'b1;
      reset_exp();

      // Reset state
      @(negedge clk);
      chk("rst_aw_ready", 64'(aw_ready_o), 64'(1));
      chk("rst_w_ready",  64'(w_ready_o),  64'(1));
      chk("rst_ar_ready", 64'(ar_ready_o), 64'(1));
      chk("rst_b_valid",  64'(b_valid_o),  64'(0));
      chk("rst_r_valid",  64'(r_valid_o),  64'(0));
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst_r_data", 64'(r_data_o), 64'(0));
      chk("rst_r_resp", 64'(r_resp_o), 64'(0));
      chk("rst_b_resp", 64'(b_resp_o), 64'(0));
      check_regs("rst");
      @(posedge clk); #1;

      // Vector table through the scoreboard
      for (int k = 0; k < 14; k++) begin
         if (vecs[k].rd) begin
            exp_r_q.push_back({vecs[k].resp, vecs[k].val});
            drive_rd(vecs[k].addr);
            collect_r($sformatf("vec%0d", k));
         end else begin
            exp_b_q.push_back(vecs[k].resp);
            drive_wr(vecs[k].addr, vecs[k].data, vecs[k].strb);
            collect_b($sformatf("vec%0d", k));
            if ((vecs[k].addr >> 2) < 32'(NR)) exp_regs[vecs[k].addr[5:2]] = vecs[k].val;
            check_regs($sformatf("vec%0d", k));
         end
      end

      // Write latency: AW+W together, B and new contents two cycles later
      aw_addr_i = 32'h10; w_data_i = 32'h13579BDF; w_strb_i = 4'hF;
      aw_valid_i = 1'b1; w_valid_i = 1'b1;
      @(negedge clk);
      chk("lat_aw_ready", 64'(aw_ready_o), 64'(1));
      chk("lat_w_ready",  64'(w_ready_o),  64'(1));
      @(posedge clk); #1;
      aw_valid_i = 1'b0; w_valid_i = 1'b0;
      @(negedge clk);
      chk("lat_bvalid_n1", 64'(b_valid_o), 64'(0));
      chk("lat_reg4_n1",   64'(reg_q_o[4*DW +: DW]), 64'(32'h0));
      @(negedge clk);
      chk("lat_bvalid_n2", 64'(b_valid_o), 64'(1));
      chk("lat_bresp_n2",  64'(b_resp_o),  64'(0));
      chk("lat_reg4_n2",   64'(reg_q_o[4*DW +: DW]), 64'(32'h13579BDF));
      exp_regs[4] = 32'h13579BDF;
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat_bvalid_done", 64'(b_valid_o), 64'(0));

      // Read latency, then back-to-back reads
      @(posedge clk); #1;
      ar_addr_i = 32'h10; ar_valid_i = 1'b1;
      @(negedge clk);
      chk("rlat_ar_ready", 64'(ar_ready_o), 64'(1));
      @(posedge clk); #1;
      ar_addr_i = 32'h08;
      @(negedge clk);
      chk("rlat_rvalid", 64'(r_valid_o), 64'(1));
      chk("rlat_rdata",  64'(r_data_o),  64'(32'h13579BDF));
      chk("rlat_rresp",  64'(r_resp_o),  64'(0));
      @(posedge clk); #1;
      ar_valid_i = 1'b0;
      @(negedge clk);
      chk("b2b_rvalid", 64'(r_valid_o), 64'(1));
      chk("b2b_rdata",  64'(r_data_o),  64'(32'hDEADBEEF));
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_rvalid_done", 64'(r_valid_o), 64'(0));
      @(posedge clk); #1;

      // W three cycles ahead of AW
      w_data_i = 32'h12345678; w_strb_i = 4'h5; w_valid_i = 1'b1;
      @(negedge clk);
      chk("wfirst_w_ready", 64'(w_ready_o), 64'(1));
      @(posedge clk); #1;
      w_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("wfirst_w_held%0d", i), 64'(w_ready_o), 64'(0));
         chk($sformatf("wfirst_bvalid%0d", i), 64'(b_valid_o), 64'(0));
         @(posedge clk); #1;
      end
      aw_addr_i = 32'h04; aw_valid_i = 1'b1;
      exp_b_q.push_back(2'b00);
      @(negedge clk);
      chk("wfirst_aw_ready", 64'(aw_ready_o), 64'(1));
      chk("wfirst_w_still",  64'(w_ready_o),  64'(0));
      @(posedge clk); #1;
      aw_valid_i = 1'b0;
      collect_b("wfirst");
      exp_regs[1] = 32'hFF34FF78;
      check_regs("wfirst");

      // B backpressure: second write held, commits on the B handshake cycle
      b_ready_i = 1'b0;
      exp_b_q.push_back(2'b10);
      exp_b_q.push_back(2'b00);
      drive_wr(32'h0C, 32'h0, 4'hF);
      n = 0;
      do begin @(negedge clk); n++; end while (!b_valid_o && n < 20);
      chk("bp_first_bvalid", 64'(b_valid_o), 64'(1));
      @(posedge clk); #1;
      drive_wr(32'h24, 32'h33334444, 4'hF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_bvalid%0d", i),   64'(b_valid_o),  64'(1));
         chk($sformatf("bp_bresp%0d", i),    64'(b_resp_o),   64'(2'b10));
         chk($sformatf("bp_aw_ready%0d", i), 64'(aw_ready_o), 64'(0));
         chk($sformatf("bp_w_ready%0d", i),  64'(w_ready_o),  64'(0));
         chk($sformatf("bp_reg9_%0d", i),    64'(reg_q_o[9*DW +: DW]), 64'(32'h0));
         @(posedge clk); #1;
      end
      b_ready_i = 1'b1;
      collect_b("bp_first");
      @(negedge clk);
      chk("bp_second_bvalid", 64'(b_valid_o), 64'(1));
      chk("bp_second_bresp",  64'(b_resp_o),  64'(exp_b_q.size() > 0 ? exp_b_q.pop_front() : 2'bxx));
      chk("bp_reg9_after",    64'(reg_q_o[9*DW +: DW]), 64'(32'h33334444));
      exp_regs[9] = 32'h33334444;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_bvalid_done", 64'(b_valid_o),  64'(0));
      chk("bp_aw_ready",    64'(aw_ready_o), 64'(1));
      @(posedge clk); #1;

      // R backpressure: ar_ready low, r_data stable, queued AR goes on release
      r_ready_i = 1'b0;
      drive_rd(32'h08);
      ar_addr_i = 32'h1C; ar_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("rbp_rvalid%0d", i),   64'(r_valid_o),  64'(1));
         chk($sformatf("rbp_rdata%0d", i),    64'(r_data_o),   64'(32'hDEADBEEF));
         chk($sformatf("rbp_ar_ready%0d", i), 64'(ar_ready_o), 64'(0));
         @(posedge clk); #1;
      end
      r_ready_i = 1'b1;
      @(negedge clk);
      chk("rbp_release_ar_ready", 64'(ar_ready_o), 64'(1));
      chk("rbp_release_rdata",    64'(r_data_o),   64'(32'hDEADBEEF));
      @(posedge clk); #1;
      ar_valid_i = 1'b0;
      @(negedge clk);
      chk("rbp_next_rvalid", 64'(r_valid_o), 64'(1));
      chk("rbp_next_rdata",  64'(r_data_o),  64'(32'hAABBCAFE));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rbp_rvalid_done", 64'(r_valid_o), 64'(0));
      @(posedge clk); #1;

      // Reset while AW is held and R is pending
      r_ready_i = 1'b0;
      drive_rd(32'h08);
      aw_addr_i = 32'h10; aw_valid_i = 1'b1;
      @(negedge clk);
      chk("mrst_aw_ready", 64'(aw_ready_o), 64'(1));
      @(posedge clk); #1;
      aw_valid_i = 1'b0;
      @(negedge clk);
      chk("mrst_aw_held",   64'(aw_ready_o), 64'(0));
      chk("mrst_r_pending", 64'(r_valid_o),  64'(1));
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(negedge clk);
      chk("mrst_b_valid",  64'(b_valid_o),  64'(0));
      chk("mrst_r_valid",  64'(r_valid_o),  64'(0));
      chk("mrst_aw_ready2", 64'(aw_ready_o), 64'(1));
      chk("mrst_w_ready",  64'(w_ready_o),  64'(1));
      chk("mrst_ar_ready", 64'(ar_ready_o), 64'(1));
      reset_exp();
      check_regs("mrst");
      @(posedge clk); #1;
      rst_i = 1'b0; r_ready_i = 1'b1;
      w_data_i = 32'hFFFFFFFF; w_strb_i = 4'hF; w_valid_i = 1'b1;
      @(negedge clk);
      chk("mrst_w_accept", 64'(w_ready_o), 64'(1));
      @(posedge clk); #1;
      w_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("mrst_no_b%0d", i), 64'(b_valid_o), 64'(0));
         chk($sformatf("mrst_no_r%0d", i), 64'(r_valid_o), 64'(0));
         @(posedge clk); #1;
      end
      check_regs("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
